// File: rtl/t05_huff_tree_ctrl.sv
// t05_huff_tree_ctrl
// Huffman tree build sequencer. Owns the shared SRAM port and repeatedly
// scans histogram + node region, feeds non-zero counts to the least-value
// finder, then writes the merged node and wipes both merged entries, until
// a single entry remains.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | waiting for start after reset
// S_CLEAR   | pulse fl_clear, rewind scan pointer
// S_RD_REQ  | read request for entry p (same-cycle ack allowed)
// S_RD_WAIT | read request held until ack
// S_SETTLE  | wait for finder latency after the last forwarded entry
// S_DECIDE  | inspect finder result: finish, fail or merge
// S_WR_NODE | write merged sum into next node slot, pulse tree_we on ack
// S_WIPE1   | write zero over the first merged entry
// S_WIPE2   | write zero over the second merged entry, bump node count
// S_DONE    | result valid; start begins a fresh build
module t05_huff_tree_ctrl #(
  parameter int HIST_N = 256,
  parameter int NODE_N = 128,
  parameter int FL_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        mem_req,
  output logic        mem_we,
  output logic [8:0]  mem_addr,
  output logic [63:0] mem_wdata,
  input  logic [63:0] mem_rdata,
  input  logic        mem_ack,
  output logic        fl_clear,
  output logic        fl_valid,
  output logic [8:0]  fl_idx,
  output logic [63:0] fl_val,
  input  logic [8:0]  fl_least1,
  input  logic [8:0]  fl_least2,
  input  logic [63:0] fl_sum,
  output logic        tree_we,
  output logic [6:0]  tree_idx,
  output logic [8:0]  tree_left,
  output logic [8:0]  tree_right,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [8:0]  root,
  output logic [7:0]  node_cnt
);

  localparam logic [8:0] ID_NONE = 9'h180;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CLEAR,
    S_RD_REQ,
    S_RD_WAIT,
    S_SETTLE,
    S_DECIDE,
    S_WR_NODE,
    S_WIPE1,
    S_WIPE2,
    S_DONE
  } state_t;

  state_t      state;
  state_t      state_n;

  logic [9:0]  p;
  logic [9:0]  scan_last_p;
  logic [7:0]  p_node;
  logic [7:0]  settle_cnt;
  logic [8:0]  l1_q;
  logic [8:0]  l2_q;
  logic [63:0] sum_q;
  logic [8:0]  node_addr;
  logic        rd_state;
  logic        rd_ack;
  logic        rd_last;
  logic        none_l1;
  logic        none_l2;
  logic        node_full;

  // SRAM word address of an entry id (histogram char or internal node)
  function automatic logic [8:0] addr_of(input logic [8:0] id);
    logic [8:0] a;
    if (id[8]) begin
      a = 9'(HIST_N) + {1'b0, id[7:0]};
    end else begin
      a = {1'b0, id[7:0]};
    end
    return a;
  endfunction

  // Scan covers every histogram slot plus the nodes created so far
  assign scan_last_p = 10'(HIST_N) + {2'b00, node_cnt} - 10'd1;
  assign p_node      = 8'(p - 10'(HIST_N));
  assign node_addr   = 9'(HIST_N) + {1'b0, node_cnt};
  assign rd_state    = (state == S_RD_REQ) || (state == S_RD_WAIT);
  assign rd_ack      = rd_state && mem_ack;
  assign rd_last     = (p == scan_last_p);
  assign none_l1     = (fl_least1 == ID_NONE);
  assign none_l2     = (fl_least2 == ID_NONE);
  assign node_full   = (node_cnt == 8'(NODE_N));

  assign busy       = (state != S_IDLE) && (state != S_DONE);
  assign done       = (state == S_DONE);
  assign tree_idx   = node_cnt[6:0];
  assign tree_left  = l1_q;
  assign tree_right = l2_q;

  // State register; reset drops out of any SRAM transaction immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state and SRAM / finder / tree strobes decoded from the state
  always_comb begin
    state_n   = state;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = 9'd0;
    mem_wdata = 64'd0;
    fl_clear  = 1'b0;
    tree_we   = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_n = S_CLEAR;
        end
      end
      S_CLEAR: begin
        fl_clear = 1'b1;
        state_n  = S_RD_REQ;
      end
      S_RD_REQ, S_RD_WAIT: begin
        mem_req  = 1'b1;
        mem_addr = p[8:0];
        if (mem_ack) begin
          state_n = rd_last ? S_SETTLE : S_RD_REQ;
        end else begin
          state_n = S_RD_WAIT;
        end
      end
      S_SETTLE: begin
        if (settle_cnt == 8'd0) begin
          state_n = S_DECIDE;
        end
      end
      S_DECIDE: begin
        if (none_l2) begin
          state_n = S_DONE;
        end else if (node_full) begin
          state_n = S_DONE;
        end else begin
          state_n = S_WR_NODE;
        end
      end
      S_WR_NODE: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = node_addr;
        mem_wdata = sum_q;
        if (mem_ack) begin
          tree_we = 1'b1;
          state_n = S_WIPE1;
        end
      end
      S_WIPE1: begin
        mem_req  = 1'b1;
        mem_we   = 1'b1;
        mem_addr = addr_of(l1_q);
        if (mem_ack) begin
          state_n = S_WIPE2;
        end
      end
      S_WIPE2: begin
        mem_req  = 1'b1;
        mem_we   = 1'b1;
        mem_addr = addr_of(l2_q);
        if (mem_ack) begin
          state_n = S_CLEAR;
        end
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  // Scan pointer, finder feed, latched merge result and build status
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p          <= 10'd0;
      settle_cnt <= 8'd0;
      fl_valid   <= 1'b0;
      fl_idx     <= 9'd0;
      fl_val     <= 64'd0;
      l1_q       <= 9'd0;
      l2_q       <= 9'd0;
      sum_q      <= 64'd0;
      node_cnt   <= 8'd0;
      err        <= 1'b0;
      root       <= ID_NONE;
    end else begin
      fl_valid <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            node_cnt <= 8'd0;
            err      <= 1'b0;
            root     <= ID_NONE;
          end
        end
        S_CLEAR: begin
          p <= 10'd0;
        end
        S_RD_REQ, S_RD_WAIT: begin
          if (rd_ack) begin
            // empty slots (unused chars, wiped entries) never reach the finder
            if (mem_rdata != 64'd0) begin
              fl_valid <= 1'b1;
              fl_val   <= mem_rdata;
              if (p < 10'(HIST_N)) begin
                fl_idx <= {1'b0, p[7:0]};
              end else begin
                fl_idx <= {1'b1, p_node};
              end
            end
            p          <= p + 10'd1;
            settle_cnt <= 8'(FL_LAT - 1);
          end
        end
        S_SETTLE: begin
          if (settle_cnt != 8'd0) begin
            settle_cnt <= settle_cnt - 8'd1;
          end
        end
        S_DECIDE: begin
          l1_q  <= fl_least1;
          l2_q  <= fl_least2;
          sum_q <= fl_sum;
          if (none_l2) begin
            // a lone survivor is the root; nothing at all means empty input
            err  <= none_l1;
            root <= fl_least1;
          end else if (node_full) begin
            err  <= 1'b1;
            root <= ID_NONE;
          end
        end
        S_WIPE2: begin
          if (mem_ack) begin
            node_cnt <= node_cnt + 8'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_t05_huff_tree_ctrl.sv
// tb_t05_huff_tree_ctrl
// Directed and randomized builds against a behavioural SRAM, a behavioural
// least-two finder, and an array-level Huffman reference model.
module tb_t05_huff_tree_ctrl;

  localparam logic [8:0] ID_NONE = 9'h180;

  logic        clk;
  logic        rst;
  logic        start;
  logic        mem_req;
  logic        mem_we;
  logic [8:0]  mem_addr;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata;
  logic        mem_ack;
  logic        fl_clear;
  logic        fl_valid;
  logic [8:0]  fl_idx;
  logic [63:0] fl_val;
  logic [8:0]  fl_least1;
  logic [8:0]  fl_least2;
  logic [63:0] fl_sum;
  logic        tree_we;
  logic [6:0]  tree_idx;
  logic [8:0]  tree_left;
  logic [8:0]  tree_right;
  logic        busy;
  logic        done;
  logic        err;
  logic [8:0]  root;
  logic [7:0]  node_cnt;

  t05_huff_tree_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack),
    .fl_clear   (fl_clear),
    .fl_valid   (fl_valid),
    .fl_idx     (fl_idx),
    .fl_val     (fl_val),
    .fl_least1  (fl_least1),
    .fl_least2  (fl_least2),
    .fl_sum     (fl_sum),
    .tree_we    (tree_we),
    .tree_idx   (tree_idx),
    .tree_left  (tree_left),
    .tree_right (tree_right),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .root       (root),
    .node_cnt   (node_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural SRAM with random ack delay ----------------
  logic [63:0] mem [0:511];
  logic [63:0] hist_init [0:255];
  logic        load;
  logic [3:0]  wait_cnt;
  int          max_delay;

  assign mem_ack   = mem_req && (wait_cnt == 4'd0);
  assign mem_rdata = mem[mem_addr];

  // SRAM: preload from hist_init, commit writes on ack, count down latency
  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < 256; i++) mem[i] <= hist_init[i];
      for (int i = 256; i < 512; i++) mem[i] <= 64'h0;
      wait_cnt <= 4'd0;
    end else if (mem_req && mem_ack) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      wait_cnt <= 4'($urandom_range(max_delay, 0));
    end else if (mem_req && wait_cnt != 4'd0) begin
      wait_cnt <= wait_cnt - 4'd1;
    end
  end

  // ---------------- behavioural least-two finder ----------------
  logic [8:0]  f_l1;
  logic [8:0]  f_l2;
  logic [63:0] f_v1;
  logic [63:0] f_v2;

  assign fl_least1 = f_l1;
  assign fl_least2 = f_l2;
  assign fl_sum    = f_v1 + f_v2;

  // Finder: keeps the two smallest values seen since clear, earliest wins ties
  always @(posedge clk or posedge rst) begin
    if (rst || fl_clear) begin
      f_l1 <= ID_NONE;
      f_l2 <= ID_NONE;
      f_v1 <= 64'h0;
      f_v2 <= 64'h0;
    end else if (fl_valid) begin
      if (f_l1 == ID_NONE || fl_val < f_v1) begin
        f_l2 <= f_l1;
        f_v2 <= f_v1;
        f_l1 <= fl_idx;
        f_v1 <= fl_val;
      end else if (f_l2 == ID_NONE || fl_val < f_v2) begin
        f_l2 <= fl_idx;
        f_v2 <= fl_val;
      end
    end
  end

  // ---------------- monitor ----------------
  logic [8:0]  act_wa [$];
  logic [63:0] act_wd [$];
  logic [24:0] act_tr [$];
  int          fv_cnt;
  int          fv_zero;
  int          stab_bad;
  int          idle_req_bad;
  logic        pend;
  logic [8:0]  p_addr;
  logic        p_we;
  logic [63:0] p_wdata;

  initial begin
    fv_cnt = 0; fv_zero = 0; stab_bad = 0; idle_req_bad = 0; pend = 1'b0;
    p_addr = '0; p_we = 1'b0; p_wdata = '0;
  end

  // Monitor: log writes/tree entries, watch request stability and idle requests
  always @(negedge clk) begin
    if (mem_req && mem_ack && mem_we) begin
      act_wa.push_back(mem_addr);
      act_wd.push_back(mem_wdata);
    end
    if (tree_we) act_tr.push_back({tree_idx, tree_left, tree_right});
    if (fl_valid) begin
      fv_cnt <= fv_cnt + 1;
      if (fl_val == 64'h0) fv_zero <= fv_zero + 1;
    end
    if (mem_req && pend &&
        (mem_addr !== p_addr || mem_we !== p_we || mem_wdata !== p_wdata))
      stab_bad <= stab_bad + 1;
    if (mem_req && !busy) idle_req_bad <= idle_req_bad + 1;
    pend    <= mem_req && !mem_ack;
    p_addr  <= mem_addr;
    p_we    <= mem_we;
    p_wdata <= mem_wdata;
  end

  // ---------------- reference model ----------------
  logic [8:0]  exp_wa [$];
  logic [63:0] exp_wd [$];
  logic [24:0] exp_tr [$];
  logic [8:0]  exp_root;
  logic        exp_err;
  int          exp_cnt;
  logic [63:0] rv [0:383];

  function automatic logic [8:0] id_of(input int a);
    if (a < 256) return 9'(a);
    return 9'h100 | 9'(a - 256);
  endfunction

  // Huffman merging over a flat array of counts in scan order
  task automatic compute_expected();
    int n;
    int b1;
    int b2;
    logic [63:0] sum;
    exp_wa.delete();
    exp_wd.delete();
    exp_tr.delete();
    for (int i = 0; i < 384; i++) rv[i] = (i < 256) ? hist_init[i[7:0]] : 64'h0;
    n = 0;
    exp_err = 1'b0;
    exp_root = ID_NONE;
    forever begin
      b1 = -1;
      for (int a = 0; a < 256 + n; a++)
        if (rv[a] != 0 && (b1 < 0 || rv[a] < rv[b1])) b1 = a;
      b2 = -1;
      for (int a = 0; a < 256 + n; a++)
        if (a != b1 && rv[a] != 0 && (b2 < 0 || rv[a] < rv[b2])) b2 = a;
      if (b1 < 0) begin exp_err = 1'b1; exp_root = ID_NONE; break; end
      if (b2 < 0) begin exp_root = id_of(b1); break; end
      if (n == 128) begin exp_err = 1'b1; exp_root = ID_NONE; break; end
      sum = rv[b1] + rv[b2];
      exp_wa.push_back(9'(256 + n)); exp_wd.push_back(sum);
      exp_wa.push_back(9'(b1));      exp_wd.push_back(64'h0);
      exp_wa.push_back(9'(b2));      exp_wd.push_back(64'h0);
      exp_tr.push_back({7'(n), id_of(b1), id_of(b2)});
      rv[256 + n] = sum;
      rv[b1] = 64'h0;
      rv[b2] = 64'h0;
      n++;
    end
    exp_cnt = n;
  endtask

  // ---------------- checking helpers ----------------
  int n_cmp;
  int n_err;
  int wr_base;
  int tr_base;
  int fv_base;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_hist();
    for (int i = 0; i < 256; i++) hist_init[i] = 64'h0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic load_and_start();
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    compute_expected();
    wr_base = act_wa.size();
    tr_base = act_tr.size();
    fv_base = fv_cnt;
    pulse_start();
  endtask

  task automatic finish_and_check(input string tag);
    int cyc;
    int nw;
    int nt;
    cyc = 0;
    while (!done && cyc < 40000) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, " done"}, 64'(done), 64'd1);
    chk({tag, " busy"}, 64'(busy), 64'd0);
    chk({tag, " err"}, 64'(err), 64'(exp_err));
    chk({tag, " root"}, 64'(root), 64'(exp_root));
    chk({tag, " node_cnt"}, 64'(node_cnt), 64'(exp_cnt));
    nw = act_wa.size() - wr_base;
    nt = act_tr.size() - tr_base;
    chk({tag, " write count"}, 64'(nw), 64'(exp_wa.size()));
    for (int k = 0; k < nw && k < exp_wa.size(); k++) begin
      chk({tag, " wr_addr"}, 64'(act_wa[wr_base + k]), 64'(exp_wa[k]));
      chk({tag, " wr_data"}, act_wd[wr_base + k], exp_wd[k]);
    end
    chk({tag, " tree count"}, 64'(nt), 64'(exp_tr.size()));
    for (int k = 0; k < nt && k < exp_tr.size(); k++)
      chk({tag, " tree entry"}, 64'(act_tr[tr_base + k]), 64'(exp_tr[k]));
    chk({tag, " req stable"}, 64'(stab_bad), 64'd0);
    chk({tag, " no idle req"}, 64'(idle_req_bad), 64'd0);
    chk({tag, " no zero fwd"}, 64'(fv_zero), 64'd0);
  endtask

  // ---------------- directed and random sequence ----------------
  initial begin
    int cyc;
    int k;
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    start = 1'b0;
    load = 1'b0;
    max_delay = 0;
    clear_hist();
    repeat (3) @(negedge clk);
    chk("reset mem_req", 64'(mem_req), 64'd0);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    chk("reset err", 64'(err), 64'd0);
    chk("reset root", 64'(root), 64'(ID_NONE));
    chk("reset node_cnt", 64'(node_cnt), 64'd0);
    chk("reset strobes", 64'({fl_clear, fl_valid, tree_we}), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // two chars merge into one node
    clear_hist(); hist_init[65] = 64'd5; hist_init[66] = 64'd3;
    load_and_start();
    finish_and_check("two chars");
    chk("two chars root const", 64'(root), 64'h100);

    // four chars, three merges
    clear_hist();
    hist_init[1] = 64'd1; hist_init[2] = 64'd1; hist_init[3] = 64'd2; hist_init[4] = 64'd4;
    load_and_start();
    finish_and_check("four chars");
    chk("four chars root const", 64'(root), 64'h102);

    // single char: restart from DONE, node count back to zero
    clear_hist(); hist_init[10] = 64'd7;
    load_and_start();
    finish_and_check("single char");
    chk("single char fl_valid", 64'(fv_cnt - fv_base), 64'd1);

    // empty histogram
    clear_hist();
    load_and_start();
    finish_and_check("empty");
    chk("empty fl_valid", 64'(fv_cnt - fv_base), 64'd0);

    // same four chars with random ack latency
    clear_hist();
    hist_init[1] = 64'd1; hist_init[2] = 64'd1; hist_init[3] = 64'd2; hist_init[4] = 64'd4;
    max_delay = 5;
    load_and_start();
    finish_and_check("four chars slow ack");

    // start mid-scan is ignored
    max_delay = 1;
    load_and_start();
    repeat (60) @(negedge clk);
    pulse_start();
    finish_and_check("start mid-scan");

    // reset while wiping the first merged entry
    max_delay = 0;
    load_and_start();
    cyc = 0;
    while (!(mem_req && mem_we && mem_wdata == 64'h0) && cyc < 5000) begin
      @(negedge clk);
      cyc++;
    end
    chk("reach wipe1", 64'(mem_req && mem_we), 64'd1);
    rst = 1'b1;
    #1;
    chk("rst wipe1 mem_req", 64'(mem_req), 64'd0);
    chk("rst wipe1 busy", 64'(busy), 64'd0);
    chk("rst wipe1 root", 64'(root), 64'(ID_NONE));
    repeat (2) @(negedge clk);
    chk("rst wipe1 no wipe", mem[1], 64'd1);
    chk("rst wipe1 node kept", mem[256], 64'd2);
    rst = 1'b0;
    @(negedge clk);
    load_and_start();
    finish_and_check("after reset");

    // randomized histograms
    for (int r = 0; r < 3; r++) begin
      clear_hist();
      k = $urandom_range(6, 2);
      for (int j = 0; j < k; j++) hist_init[$urandom_range(255, 0)] = 64'($urandom_range(1000, 1));
      max_delay = $urandom_range(3, 0);
      load_and_start();
      finish_and_check("random");
    end

    // large counts exercise 64-bit wrap of the sums
    clear_hist();
    for (int j = 0; j < 4; j++)
      hist_init[$urandom_range(255, 0)] = {1'b1, 31'($urandom), 32'($urandom)};
    max_delay = 0;
    load_and_start();
    finish_and_check("large counts");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
